// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, fault codes and FSM states.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RESP
   } lsu_state_t;

   // The reserved size code is executed as a full word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == SZ_RSVD) ? SZ_WORD : size;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane handling: extract-and-extend for loads, lane merge for read-modify-write stores.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [4:0]  shift;
   logic [31:0] lane_mask;
   logic [31:0] lane_bits;

   always_comb begin
      shift     = 5'd0;
      lane_mask = 32'hFFFF_FFFF;
      // Offset 0 is the most significant lane, so the shift counts down from the top.
      case (size)
         SZ_BYTE: begin
            shift     = {~offset, 3'b000};
            lane_mask = 32'h0000_00FF;
         end
         SZ_HALF: begin
            shift     = offset[1] ? 5'd0 : 5'd16;
            lane_mask = 32'h0000_FFFF;
         end
         default: begin
         end
      endcase

      lane_bits = (rd_word >> shift) & lane_mask;

      case (size)
         SZ_BYTE: load_data = zero_ext ? lane_bits : {{24{lane_bits[7]}}, lane_bits[7:0]};
         SZ_HALF: load_data = zero_ext ? lane_bits : {{16{lane_bits[15]}}, lane_bits[15:0]};
         default: load_data = rd_word;
      endcase

      store_word = (rd_word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte/half/word accesses over a word-only big-endian memory.
// Macro LSU_ALIGN_CHECK_EN: fault misaligned accesses; when undefined they are force-aligned.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_fault,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wr_data,
   output logic              mem_wr,
   output logic              mem_rd,
   input  logic [31:0]       mem_rd_data
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

   lsu_state_t state, state_next;

   logic              store_q;
   logic              zero_ext_q;
   logic [1:0]        size_q;
   logic [1:0]        offset_q;
   logic [31:0]       wdata_q;

   logic              accept;
   logic [1:0]        size_eff;
   logic [ADDR_W-1:0] addr_eff;
   logic [ADDR_W-1:0] word_addr;
   logic              misalign;
   logic              out_of_range;
   logic [1:0]        fault;

   logic [31:0]       load_data;
   logic [31:0]       store_word;

   logic              mem_rd_next;
   logic              mem_wr_next;
   logic [31:0]       mem_addr_next;
   logic [31:0]       mem_wr_data_next;
   logic              resp_valid_next;
   logic [31:0]       resp_rdata_next;
   logic [1:0]        resp_fault_next;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      size_eff = norm_size(req_size);
      addr_eff = req_addr;
      misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      if (size_eff == SZ_HALF)
         misalign = req_addr[0];
      else if (size_eff == SZ_WORD)
         misalign = |req_addr[1:0];
`else
      if (size_eff == SZ_HALF)
         addr_eff[0] = 1'b0;
      else if (size_eff == SZ_WORD)
         addr_eff[1:0] = 2'b00;
`endif
      word_addr = {addr_eff[ADDR_W-1:2], 2'b00};
      // Extra carry bit keeps the +3 from wrapping at the top of the address space.
      out_of_range = ({1'b0, word_addr} + (ADDR_W+1)'(3)) >= LIMIT;
      if (misalign)
         fault = FLT_MISALIGN;
      else if (out_of_range)
         fault = FLT_RANGE;
      else
         fault = FLT_NONE;
   end

   lsu_lane u_lane (
      .offset     (offset_q),
      .size       (size_q),
      .zero_ext   (zero_ext_q),
      .rd_word    (mem_rd_data),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_comb begin
      state_next       = state;
      mem_rd_next      = 1'b0;
      mem_wr_next      = 1'b0;
      mem_addr_next    = mem_addr;
      mem_wr_data_next = mem_wr_data;
      resp_valid_next  = 1'b0;
      resp_rdata_next  = resp_rdata;
      resp_fault_next  = resp_fault;

      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (fault != FLT_NONE) begin
                  state_next      = ST_RESP;
                  resp_valid_next = 1'b1;
                  resp_rdata_next = 32'h0;
                  resp_fault_next = fault;
               end else begin
                  mem_addr_next = 32'(word_addr);
                  if (req_is_store && size_eff == SZ_WORD) begin
                     state_next       = ST_WR;
                     mem_wr_next      = 1'b1;
                     mem_wr_data_next = req_wdata;
                  end else begin
                     state_next  = ST_RD;
                     mem_rd_next = 1'b1;
                  end
               end
            end
         end
         ST_RD: begin
            if (store_q) begin
               state_next       = ST_WR;
               mem_wr_next      = 1'b1;
               mem_wr_data_next = store_word;
            end else begin
               state_next      = ST_RESP;
               resp_valid_next = 1'b1;
               resp_rdata_next = load_data;
               resp_fault_next = FLT_NONE;
            end
         end
         ST_WR: begin
            state_next      = ST_RESP;
            resp_valid_next = 1'b1;
            resp_rdata_next = 32'h0;
            resp_fault_next = FLT_NONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= 32'h0;
         mem_wr_data <= 32'h0;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'h0;
         resp_fault  <= FLT_NONE;
      end else begin
         state       <= state_next;
         mem_rd      <= mem_rd_next;
         mem_wr      <= mem_wr_next;
         mem_addr    <= mem_addr_next;
         mem_wr_data <= mem_wr_data_next;
         resp_valid  <= resp_valid_next;
         resp_rdata  <= resp_rdata_next;
         resp_fault  <= resp_fault_next;
      end
   end

   // Request fields are held for the whole access; they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         store_q    <= req_is_store;
         zero_ext_q <= req_unsigned;
         size_q     <= size_eff;
         offset_q   <= addr_eff[1:0];
         wdata_q    <= req_wdata;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver queues expected responses, a monitor checks them.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_rd_data;

   logic [31:0] mem [0:63];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic [1:0]  fault;
      int          due;
      int          nrd;
      int          nwr;
      logic [31:0] maddr;
      logic [31:0] mwd;
   } exp_t;

   exp_t sbq[$];
   int   next_id = 0;

   load_store_unit dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault),
      .mem_addr     (mem_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr       (mem_wr),
      .mem_rd       (mem_rd),
      .mem_rd_data  (mem_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rd_data = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_wr)
         mem[mem_addr[7:2]] <= mem_wr_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=present expected=absent", name);
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit push,
                        input logic [31:0] rdata, input logic [1:0] flt, input int lat,
                        input int nrd, input int nwr, input logic [31:0] maddr,
                        input logic [31:0] mwd, output int acc);
      int guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout actual=0 expected=1");
         finish_run();
      end
      req_valid    = 1'b1;
      req_is_store = st;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      @(posedge clk);
      #1;
      acc       = cyc;
      req_valid = 1'b0;
      if (push) begin
         e.id    = next_id;
         e.rdata = rdata;
         e.fault = flt;
         e.due   = acc + lat - 1;
         e.nrd   = nrd;
         e.nwr   = nwr;
         e.maddr = maddr;
         e.mwd   = mwd;
         sbq.push_back(e);
      end
      next_id++;
   endtask

   // Monitor: strobe legality, strobe address/data, and response contents and timing.
   initial begin
      int   rd_cnt;
      int   wr_cnt;
      exp_t e;
      rd_cnt = 0;
      wr_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            rd_cnt = 0;
            wr_cnt = 0;
         end else begin
            if (mem_rd && mem_wr)
               unexpected("rd_and_wr_together");
            if (mem_rd) begin
               rd_cnt++;
               if (sbq.size() == 0)
                  unexpected("stray_mem_rd");
               else
                  check($sformatf("rd_addr#%0d", sbq[0].id), mem_addr, sbq[0].maddr);
            end
            if (mem_wr) begin
               wr_cnt++;
               if (sbq.size() == 0)
                  unexpected("stray_mem_wr");
               else begin
                  check($sformatf("wr_addr#%0d", sbq[0].id), mem_addr, sbq[0].maddr);
                  check($sformatf("wr_data#%0d", sbq[0].id), mem_wr_data, sbq[0].mwd);
               end
            end
            if (resp_valid) begin
               if (sbq.size() == 0)
                  unexpected("stray_resp_valid");
               else begin
                  e = sbq.pop_front();
                  check($sformatf("rdata#%0d", e.id), resp_rdata, e.rdata);
                  check($sformatf("fault#%0d", e.id), {30'h0, resp_fault}, {30'h0, e.fault});
                  check($sformatf("resp_cycle#%0d", e.id), cyc, e.due);
                  check($sformatf("rd_count#%0d", e.id), rd_cnt, e.nrd);
                  check($sformatf("wr_count#%0d", e.id), wr_cnt, e.nwr);
               end
               rd_cnt = 0;
               wr_cnt = 0;
            end
         end
      end
   end

   initial begin
      int a1;
      int a2;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[8]  = 32'h80F0A5C3;
      mem[63] = 32'h12345678;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_fault", {30'h0, resp_fault}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wr_data", mem_wr_data, 32'h0);
      check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
      reset = 1'b0;

      // Extension on word 0x80F0A5C3 at 0x20
      issue(0, 2'b00, 0, 32'h20, 0, 1, 32'hFFFFFF80, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(0, 2'b00, 1, 32'h20, 0, 1, 32'h00000080, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(0, 2'b01, 0, 32'h22, 0, 1, 32'hFFFFA5C3, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(0, 2'b01, 1, 32'h22, 0, 1, 32'h0000A5C3, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(0, 2'b01, 0, 32'h20, 0, 1, 32'hFFFF80F0, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(0, 2'b00, 0, 32'h23, 0, 1, 32'hFFFFFFC3, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(0, 2'b00, 1, 32'h21, 0, 1, 32'h000000F0, 2'b00, 2, 1, 0, 32'h20, 0, a1);

      // Sub-word and word stores
      issue(1, 2'b00, 0, 32'h21, 32'h000000EE, 1, 32'h0, 2'b00, 3, 1, 1, 32'h20, 32'h80EEA5C3, a1);
      issue(0, 2'b10, 0, 32'h20, 0, 1, 32'h80EEA5C3, 2'b00, 2, 1, 0, 32'h20, 0, a1);
      issue(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 1, 32'h0, 2'b00, 2, 0, 1, 32'h40, 32'hDEADBEEF, a1);
      issue(0, 2'b10, 0, 32'h40, 0, 1, 32'hDEADBEEF, 2'b00, 2, 1, 0, 32'h40, 0, a1);
      issue(1, 2'b01, 0, 32'h42, 32'hFFFF1234, 1, 32'h0, 2'b00, 3, 1, 1, 32'h40, 32'hDEAD1234, a1);
      issue(0, 2'b11, 0, 32'h40, 0, 1, 32'hDEAD1234, 2'b00, 2, 1, 0, 32'h40, 0, a1);

      // Misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
      issue(0, 2'b10, 0, 32'h22, 0, 1, 32'h0, 2'b01, 1, 0, 0, 32'h0, 0, a1);
`else
      issue(0, 2'b10, 0, 32'h22, 0, 1, 32'h80EEA5C3, 2'b00, 2, 1, 0, 32'h20, 0, a1);
`endif

      // Back-to-back word loads, top-of-memory word included
      issue(0, 2'b10, 0, 32'h40, 0, 1, 32'hDEAD1234, 2'b00, 2, 1, 0, 32'h40, 0, a1);
      check("busy_req_ready", {31'h0, req_ready}, 32'h0);
      issue(0, 2'b10, 0, 32'hFC, 0, 1, 32'h12345678, 2'b00, 2, 1, 0, 32'hFC, 0, a2);
      check("issue_interval", a2 - a1, 3);

      // Range boundary and fault priority
      issue(0, 2'b10, 0, 32'h100, 0, 1, 32'h0, 2'b10, 1, 0, 0, 32'h0, 0, a1);
`ifdef LSU_ALIGN_CHECK_EN
      issue(0, 2'b01, 0, 32'h101, 0, 1, 32'h0, 2'b01, 1, 0, 0, 32'h0, 0, a1);
`else
      issue(0, 2'b01, 0, 32'h101, 0, 1, 32'h0, 2'b10, 1, 0, 0, 32'h0, 0, a1);
`endif
      issue(0, 2'b00, 1, 32'hFF, 0, 1, 32'h00000078, 2'b00, 2, 1, 0, 32'hFC, 0, a1);

      // Reset during the read cycle of a half store drops it
      issue(1, 2'b01, 0, 32'h20, 32'h00005555, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 0, a1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("post_reset_req_ready", {31'h0, req_ready}, 32'h1);
      check("post_reset_mem_wr", {31'h0, mem_wr}, 32'h0);
      check("post_reset_resp_valid", {31'h0, resp_valid}, 32'h0);
      repeat (4) @(negedge clk);
      check("post_reset_mem_0x20", mem[8], 32'h80EEA5C3);
      issue(0, 2'b10, 0, 32'h20, 0, 1, 32'h80EEA5C3, 2'b00, 2, 1, 0, 32'h20, 0, a1);

      for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      finish_run();
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit of the 32-bit MIPS core. Sits between the EX/MEM pipeline register and the data memory.
- Accepts one load/store request at a time and converts byte/half/word accesses into the memory's word-only, big-endian, byte-addressed read/write interface.
- Sub-word stores use read-modify-write. Load results are sign- or zero-extended, and misaligned or out-of-range accesses are reported.

Parameters:
- ADDR_W, 32, address width.
- MEM_BYTES, 256, data memory size in bytes. Sets the range-check limit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- req_valid  input  1  pipeline presents a request.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_is_store  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  input  1  zero-extend loads (lbu/lhu).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; byte/half taken from the low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  2  00 ok, 01 misaligned, 10 out of range.
- mem_addr  output  32  word-aligned address to data memory.
- mem_wr_data  output  32  write word.
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read strobe.
- mem_rd_data  input  32  combinational read data from memory.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=00; mem_addr=0; mem_wr_data=0; mem_wr=0; mem_rd=0.
- Acceptance: a request is accepted on the edge where req_valid & req_ready. Accepted fields are latched. Requests outside IDLE are ignored, and the pipeline must hold them.
- States: IDLE, RD, WR, RESP.
- Fault check at accept:
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: (addr & ~3) + 3 >= MEM_BYTES.
  - Misaligned has priority over out of range.
  - A faulting request goes IDLE→RESP. No memory strobe is asserted. resp_valid at T+1.
- Word load: IDLE→RD→RESP.
  - RD cycle (T+1): mem_rd=1, mem_addr=addr&~3. mem_rd_data is captured at the end of T+1.
  - resp_valid at T+2.
- Sub-word load: same flow and timing as word load.
  - Lane select is big-endian: offset 0 = bits[31:24], offset 3 = bits[7:0]. Half at offset 0 = [31:16], offset 2 = [15:0].
  - The selected lane is sign-extended unless req_unsigned=1.
- Word store: IDLE→WR→RESP. WR cycle (T+1): mem_wr=1, mem_wr_data=req_wdata. resp_valid at T+2.
- Byte/half store: IDLE→RD→WR→RESP.
  - RD cycle: read the word.
  - WR cycle: write the read word with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - resp_valid at T+3.
- Strobes: mem_rd and mem_wr are registered outputs and are never high in the same cycle. Each is high for exactly one cycle per access.
- Response: resp_valid is a single-cycle pulse with no back-pressure. RESP→IDLE always. req_ready returns high the cycle after RESP, so back-to-back word loads issue every 3 cycles.
- Reset mid-operation: state returns to IDLE at the reset edge and the in-flight request is dropped with no resp_valid. A write whose WR cycle coincided with the reset cycle still completes as a whole word; no partial write is possible.
- Reserved size 11 behaves exactly as word.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: misaligned accesses fault as described above.
- Undefined: address low bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0). The access proceeds normally, and resp_fault[0] is tied to 0. The range check is always present.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), fault codes (FLT_NONE, FLT_MISALIGN, FLT_RANGE), state enum.
- Sub-module lsu_lane: purely combinational. Performs byte/half extract-and-extend for loads and merge for stores, keyed by offset, size and unsigned.

Test Plan:
- Sign/zero extension, memory word 0x80F0A5C3 at 0x20:
  - lb 0x20 → resp_rdata 0xFFFFFF80 at T+2.
  - lbu 0x20 → 0x00000080.
  - lh 0x22 → 0xFFFFA5C3.
  - lhu 0x22 → 0x0000A5C3.
- sb 0x21, wdata 0x000000EE → RD at T+1, WR at T+2 with mem_wr_data 0x80EEA5C3, resp at T+3. A following lw 0x20 returns 0x80EEA5C3.
- sw 0x40, wdata 0xDEADBEEF → single mem_wr at T+1, resp at T+2, mem_rd never high. lw 0x40 returns 0xDEADBEEF.
- Misaligned lw 0x22 → resp_fault 01 at T+1, no mem_rd/mem_wr. With the macro undefined: reads 0x20, fault 00.
- Range: lw 0xFC → ok; lw 0x100 → fault 10, no strobes; lh 0x101 → fault 01 (priority).
- reset asserted during the RD cycle of an sh → no resp_valid, no mem_wr, memory unchanged. req_ready=1 the cycle after reset deasserts.
